// File: rtl/rv_fetch_pkg.sv
// Shared fetch-side definitions: FSM state encoding and well-known instruction words.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] HALT_INSN = 32'h0010_0073;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch bus: ROM read port plus the valid/ready instruction channel towards decode.
interface ifetch_unit_if #(
    parameter int PC_W   = 32,
    parameter int ROM_AW = 8
);
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_read_en;
    logic              rom_ce;
    logic [31:0]       rom_data;
    logic [31:0]       instr;
    logic [PC_W-1:0]   instr_pc;
    logic              instr_valid;
    logic              dec_ready;

    modport master (
        output rom_addr, rom_read_en, rom_ce, instr, instr_pc, instr_valid,
        input  rom_data, dec_ready
    );

    modport slave (
        input  rom_addr, rom_read_en, rom_ce, instr, instr_pc, instr_valid,
        output rom_data, dec_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC register, fetch FSM and the output register feeding decode.
module ifetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter int          ROM_AW    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_INSN = rv_fetch_pkg::HALT_INSN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic            fetch_fault,
    ifetch_unit_if.master   bus
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc;
    logic            pc_ok;
    logic            slot_free;
    logic            fire;
    logic            redirect_take;

    // The PC must be word aligned and point inside the ROM.
    assign pc_ok         = (pc[1:0] == 2'b00) && (pc[PC_W-1:ROM_AW+2] == '0);
    assign slot_free     = !bus.instr_valid || bus.dec_ready;
    assign redirect_take = redirect_valid && (state != ST_FAULT);
    assign fire          = (state == ST_FETCH) && enable && slot_free && !redirect_valid && pc_ok;

    assign bus.rom_addr    = pc[ROM_AW+1:2];
    assign bus.rom_ce      = fire;
    assign bus.rom_read_en = fire;
    assign halted          = (state == ST_HALT);
    assign fetch_fault     = (state == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_take) begin
            state_nxt = enable ? ST_FETCH : ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (enable) state_nxt = ST_FETCH;
                ST_FETCH: begin
                    if (!enable)
                        state_nxt = ST_IDLE;
                    else if (!pc_ok)
                        state_nxt = ST_FAULT;
                    else if (fire && (bus.rom_data == HALT_INSN))
                        state_nxt = ST_HALT;
                end
                ST_HALT:  state_nxt = ST_HALT;
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output register: a redirect flushes, a fire captures, an accepted word drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc              <= RESET_PC[PC_W-1:0];
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.instr_valid <= 1'b0;
        end else if (redirect_take) begin
            pc              <= redirect_pc;
            bus.instr_valid <= 1'b0;
        end else if (fire) begin
            pc              <= pc + PC_W'(4);
            bus.instr       <= bus.rom_data;
            bus.instr_pc    <= pc;
            bus.instr_valid <= 1'b1;
        end else if (bus.dec_ready) begin
            bus.instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: ROM model, scoreboard of expected deliveries, directed scenarios.
module tb_ifetch_unit;
    import rv_fetch_pkg::*;

    localparam int PC_W   = 32;
    localparam int ROM_AW = 8;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            halted;
    logic            fetch_fault;

    logic [31:0] rom [256];
    exp_t        sbq [$];
    int          n_checks = 0;
    int          n_fail = 0;

    ifetch_unit_if #(.PC_W(PC_W), .ROM_AW(ROM_AW)) bus ();

    ifetch_unit #(.PC_W(PC_W), .ROM_AW(ROM_AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .fetch_fault    (fetch_fault),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int word_idx);
        exp_t e;
        e.insn = rom[word_idx];
        e.pc   = 32'(word_idx) << 2;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        enable         = 1'b0;
        bus.dec_ready  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_ce",    {31'd0, bus.rom_ce}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_halt",  {31'd0, halted}, 32'd0);
        step(2);
        #2 rst_n = 1'b1;
        step(1);
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected delivery.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.dec_ready) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected", {31'd0, bus.instr_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_instr", bus.instr, e.insn);
                check("sb_pc",    bus.instr_pc, e.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 | 32'(i);

        // 1: straight-line stream A..D
        do_reset();
        for (int i = 0; i < 4; i++) push(i);
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(5);
        enable = 1'b0;
        step(2);
        check("t1_drained", {31'd0, bus.instr_valid}, 32'd0);

        // 2: backpressure while B is valid
        do_reset();
        for (int i = 0; i < 3; i++) push(i);
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(3);
        bus.dec_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t2_ce_hold",   {31'd0, bus.rom_ce}, 32'd0);
            check("t2_instr_hold", bus.instr, rom[1]);
            check("t2_pc_hold",   bus.instr_pc, 32'h4);
            check("t2_addr_hold", {24'd0, bus.rom_addr}, 32'd2);
            step(1);
        end
        bus.dec_ready = 1'b1;
        #1 check("t2_ce_resume", {31'd0, bus.rom_ce}, 32'd1);
        step(1);
        check("t2_c_next", bus.instr, rom[2]);
        enable = 1'b0;
        step(2);

        // 3: redirect flushes the pending word
        do_reset();
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(2);
        bus.dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1 check("t3_no_fire", {31'd0, bus.rom_ce}, 32'd0);
        step(1);
        redirect_valid = 1'b0; bus.dec_ready = 1'b1;
        check("t3_flushed", {31'd0, bus.instr_valid}, 32'd0);
        #1;
        check("t3_addr", {24'd0, bus.rom_addr}, 32'h10);
        check("t3_ce",   {31'd0, bus.rom_ce}, 32'd1);
        push(16);
        step(1);
        enable = 1'b0;
        step(2);

        // 4: halt on EBREAK, resume by redirect
        do_reset();
        rom[2] = HALT_INSN;
        for (int i = 0; i < 3; i++) push(i);
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(4);
        check("t4_halted",  {31'd0, halted}, 32'd1);
        check("t4_ce_off",  {31'd0, bus.rom_ce}, 32'd0);
        check("t4_ebreak",  bus.instr, HALT_INSN);
        step(2);
        check("t4_still_halted", {31'd0, halted}, 32'd1);
        check("t4_ce_still_off", {31'd0, bus.rom_ce}, 32'd0);
        check("t4_idle_out",     {31'd0, bus.instr_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        push(0); push(1);
        #1;
        check("t4_resumed", {31'd0, halted}, 32'd0);
        check("t4_ce_on",   {31'd0, bus.rom_ce}, 32'd1);
        step(2);
        enable = 1'b0;
        step(2);
        rom[2] = 32'hC0DE_0002;

        // 5a: misaligned redirect faults on the following FETCH cycle
        do_reset();
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        step(1);
        redirect_valid = 1'b0;
        check("t5_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
        #1 check("t5_ce_bad_pc", {31'd0, bus.rom_ce}, 32'd0);
        step(1);
        check("t5_fault", {31'd0, fetch_fault}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(1);
        redirect_valid = 1'b0;
        check("t5_redir_ignored", {31'd0, fetch_fault}, 32'd1);
        check("t5_ce_off",        {31'd0, bus.rom_ce}, 32'd0);
        check("t5_addr_kept",     {24'd0, bus.rom_addr}, 32'd1);
        step(2);
        check("t5_sticky", {31'd0, fetch_fault}, 32'd1);
        do_reset();
        check("t5_cleared", {31'd0, fetch_fault}, 32'd0);

        // 5b: last ROM word is delivered, then the wrapped-out PC faults
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h3FC;
        step(1);
        redirect_valid = 1'b0;
        push(255);
        #1;
        check("t5b_ce",   {31'd0, bus.rom_ce}, 32'd1);
        check("t5b_addr", {24'd0, bus.rom_addr}, 32'hFF);
        step(1);
        check("t5b_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
        step(1);
        check("t5b_fault",  {31'd0, fetch_fault}, 32'd1);
        check("t5b_ce_off", {31'd0, bus.rom_ce}, 32'd0);
        enable = 1'b0;

        // 6: asynchronous reset in the middle of a stream
        do_reset();
        push(0);
        enable = 1'b1; bus.dec_ready = 1'b1;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        check("t6_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("t6_instr", bus.instr, 32'd0);
        check("t6_ipc",   bus.instr_pc, 32'd0);
        check("t6_ce",    {31'd0, bus.rom_ce}, 32'd0);
        check("t6_addr",  {24'd0, bus.rom_addr}, 32'd0);
        step(1);
        #2 rst_n = 1'b1;
        push(0); push(1);
        step(3);
        enable = 1'b0;
        step(3);

        check("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
